// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg -- shared types and constants for the instruction fetch unit.
//   fetch_state_t : fetch FSM state encoding (IDLE/FETCH/HOLD/DROP)
//   ADDR_W_DEF    : default address / program counter width
//   INSTR_W_DEF   : default instruction word width
//   NOP_INSTR     : instruction word left in instr when a held word is discarded
package fetch_unit_pkg;

   localparam int ADDR_W_DEF  = 16;
   localparam int INSTR_W_DEF = 32;

   // addi x0, x0, 0
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2,
      DROP  = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/fetch_timeout.sv
// fetch_timeout -- watchdog for an outstanding instruction-memory request.
// Counts cycles while enable=1; expired goes high combinationally in the
// LIMIT-th enabled cycle, so the owner can abandon the request on that edge.
//   clock   : rising-edge clock
//   reset   : asynchronous active-low reset, clears the count
//   clear   : synchronous count clear (no request outstanding, or ack seen)
//   enable  : a request is waiting for ack this cycle
//   expired : LIMIT waiting cycles have elapsed
module fetch_timeout
   import fetch_unit_pkg::*;
#(
   parameter int unsigned LIMIT = 255
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CNT_W = $clog2(LIMIT + 1);

   logic [CNT_W-1:0] cnt;

   assign expired = enable && (cnt == CNT_W'(LIMIT - 1));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable && !expired) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit -- single-outstanding instruction fetch with decode handshake.
// Issues one request at the current PC, holds the returned word for decode,
// and computes the next PC (sequential, branch redirect, or hold).
// Optional watchdog: define FETCH_TIMEOUT_EN to abandon requests that see no
// ack within TIMEOUT_CYC cycles and raise the sticky fetchErr flag.
//   clock, reset               : rising-edge clock, async active-low reset
//   pcAddy                     : current PC
//   hlt                        : blocks starting a new fetch
//   branchTaken, branchTarget  : redirect strobe and address
//   imemReq/imemAddr/imemAck/imemData : instruction memory port
//   instr/instrValid/instrReady       : decode handshake
//   nextAddy                   : next PC value (combinational)
//   fetchErr                   : sticky timeout flag (FETCH_TIMEOUT_EN only)
//
// state | meaning
// IDLE  | no request outstanding, waiting for hlt=0 and no redirect
// FETCH | request outstanding, result will be delivered to decode
// HOLD  | word captured, waiting for decode to accept it
// DROP  | request outstanding but redirected; result will be thrown away
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int          ADDR_W      = ADDR_W_DEF,
   parameter int          INSTR_W     = INSTR_W_DEF,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [ADDR_W-1:0]  pcAddy,
   input  logic               hlt,
   input  logic               branchTaken,
   input  logic [ADDR_W-1:0]  branchTarget,
   output logic               imemReq,
   output logic [ADDR_W-1:0]  imemAddr,
   input  logic               imemAck,
   input  logic [INSTR_W-1:0] imemData,
   output logic [INSTR_W-1:0] instr,
   output logic               instrValid,
   input  logic               instrReady,
   output logic [ADDR_W-1:0]  nextAddy
`ifdef FETCH_TIMEOUT_EN
   ,
   output logic               fetchErr
`endif
);

   fetch_state_t state;
   logic         tmo_expired;

`ifdef FETCH_TIMEOUT_EN
   logic busy;

   assign busy = (state == FETCH) || (state == DROP);

   // The count runs across FETCH->DROP: it is the same outstanding request.
   fetch_timeout #(
      .LIMIT (TIMEOUT_CYC)
   ) u_fetch_timeout (
      .clock   (clock),
      .reset   (reset),
      .clear   (!busy || imemAck),
      .enable  (busy && !imemAck),
      .expired (tmo_expired)
   );
`else
   assign tmo_expired = 1'b0;

   // Watchdog compiled out; TIMEOUT_CYC stays so both builds share one
   // parameter list. Nothing is built here.
   if (TIMEOUT_CYC == 0) begin : g_no_watchdog
   end
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         imemReq    <= 1'b0;
         imemAddr   <= '0;
         instr      <= '0;
         instrValid <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
         fetchErr   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (!hlt && !branchTaken) begin
                  imemAddr <= pcAddy;
                  imemReq  <= 1'b1;
                  state    <= FETCH;
               end
            end
            FETCH: begin
               // A returning ack wins over an expiring watchdog.
               if (imemAck) begin
                  imemReq <= 1'b0;
                  if (branchTaken) begin
                     state <= IDLE;
                  end else begin
                     instr      <= imemData;
                     instrValid <= 1'b1;
                     state      <= HOLD;
                  end
               end else if (tmo_expired) begin
                  imemReq <= 1'b0;
                  state   <= IDLE;
`ifdef FETCH_TIMEOUT_EN
                  fetchErr <= 1'b1;
`endif
               end else if (branchTaken) begin
                  state <= DROP;
               end
            end
            HOLD: begin
               if (branchTaken) begin
                  instr      <= INSTR_W'(NOP_INSTR);
                  instrValid <= 1'b0;
                  state      <= IDLE;
               end else if (instrReady) begin
                  instrValid <= 1'b0;
                  state      <= IDLE;
               end
            end
            DROP: begin
               if (imemAck) begin
                  imemReq <= 1'b0;
                  state   <= IDLE;
               end else if (tmo_expired) begin
                  imemReq <= 1'b0;
                  state   <= IDLE;
`ifdef FETCH_TIMEOUT_EN
                  fetchErr <= 1'b1;
`endif
               end
            end
            default: begin
               imemReq <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

   // Redirect outranks the sequential advance; otherwise the PC holds.
   always_comb begin
      nextAddy = pcAddy;
      if (!reset) begin
         nextAddy = '0;
      end else if (branchTaken) begin
         nextAddy = branchTarget;
      end else if ((state == HOLD) && instrReady) begin
         nextAddy = imemAddr + ADDR_W'(1);
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   localparam int AW = 16;
   localparam int IW = 32;
   localparam int TO = 8;

   logic          clock = 1'b0;
   logic          reset;
   logic          hlt = 1'b1;
   logic          branchTaken = 1'b0;
   logic          imemAck = 1'b0;
   logic          instrReady = 1'b0;
   logic [AW-1:0] pcAddy = '0;
   logic [AW-1:0] branchTarget = '0;
   logic [IW-1:0] imemData = '0;

   logic          imemReq;
   logic          instrValid;
   logic [AW-1:0] imemAddr;
   logic [AW-1:0] nextAddy;
   logic [IW-1:0] instr;
`ifdef FETCH_TIMEOUT_EN
   logic          fetchErr;
`endif

   fetch_unit #(
      .ADDR_W      (AW),
      .INSTR_W     (IW),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .pcAddy       (pcAddy),
      .hlt          (hlt),
      .branchTaken  (branchTaken),
      .branchTarget (branchTarget),
      .imemReq      (imemReq),
      .imemAddr     (imemAddr),
      .imemAck      (imemAck),
      .imemData     (imemData),
      .instr        (instr),
      .instrValid   (instrValid),
      .instrReady   (instrReady),
      .nextAddy     (nextAddy)
`ifdef FETCH_TIMEOUT_EN
      ,
      .fetchErr     (fetchErr)
`endif
   );

   always #5 clock = ~clock;

   int vectors     = 0;
   int miscompares = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: is a request outstanding, will its result be
   // thrown away, is a word held for decode, and how long has the request waited.
   bit            m_busy = 0;
   bit            m_drop = 0;
   bit            m_have = 0;
   bit            m_err  = 0;
   int            m_wait = 0;
   logic [AW-1:0] m_addr  = '0;
   logic [IW-1:0] m_instr = '0;

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         m_busy = 0; m_drop = 0; m_have = 0; m_err = 0; m_wait = 0;
         m_addr = '0; m_instr = '0;
      end else if (m_have) begin
         if (branchTaken) begin
            m_have  = 0;
            m_instr = IW'(NOP_INSTR);
         end else if (instrReady) begin
            m_have = 0;
         end
      end else if (m_busy) begin
         if (imemAck) begin
            m_busy = 0;
            if (!m_drop && !branchTaken) begin
               m_have  = 1;
               m_instr = imemData;
            end
            m_drop = 0;
         end else begin
            if (branchTaken) m_drop = 1;
            m_wait++;
`ifdef FETCH_TIMEOUT_EN
            if (m_wait == TO) begin
               m_busy = 0;
               m_drop = 0;
               m_err  = 1;
            end
`endif
         end
      end else if (!hlt && !branchTaken) begin
         m_busy = 1;
         m_drop = 0;
         m_wait = 0;
         m_addr = pcAddy;
      end
   end

   always @(negedge clock) begin
      logic [AW-1:0] exp_next;
      if (!reset)                    exp_next = '0;
      else if (branchTaken)          exp_next = branchTarget;
      else if (m_have && instrReady) exp_next = AW'((int'(m_addr) + 1) % (1 << AW));
      else                           exp_next = pcAddy;
      chk("model_imemReq", imemReq, m_busy);
      chk("model_imemAddr", imemAddr, m_addr);
      chk("model_instrValid", instrValid, m_have);
      chk("model_instr", instr, m_instr);
      chk("model_nextAddy", nextAddy, exp_next);
`ifdef FETCH_TIMEOUT_EN
      chk("model_fetchErr", fetchErr, m_err);
`endif
   end

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      reset = 1'b0;
      repeat (3) tick();
      chk("rst_imemReq", imemReq, 0);
      chk("rst_imemAddr", imemAddr, 0);
      chk("rst_instrValid", instrValid, 0);
      chk("rst_instr", instr, 0);
      chk("rst_nextAddy", nextAddy, 0);
      reset = 1'b1;
      tick();
      chk("post_rst_idle_hlt", imemReq, 0);

      // basic fetch, ack two cycles after request
      pcAddy = 16'h0010; hlt = 1'b0;
      tick();
      chk("s1_req", imemReq, 1);
      chk("s1_addr", imemAddr, 16'h0010);
      hlt = 1'b1;
      tick();
      tick();
      chk("s1_req_wait", imemReq, 1);
      chk("s1_addr_stable", imemAddr, 16'h0010);
      imemAck = 1'b1; imemData = 32'hDEAD_BEEF; instrReady = 1'b1;
      tick();
      imemAck = 1'b0;
      #1;
      chk("s1_valid", instrValid, 1);
      chk("s1_instr", instr, 32'hDEAD_BEEF);
      chk("s1_next", nextAddy, 16'h0011);
      chk("s1_req_off", imemReq, 0);
      tick();
      chk("s1_valid_pulse", instrValid, 0);
      instrReady = 1'b0;

      // wrap of sequential address
      pcAddy = 16'hFFFF; hlt = 1'b0; instrReady = 1'b1;
      tick();
      hlt = 1'b1; imemAck = 1'b1; imemData = 32'h1234_5678;
      tick();
      imemAck = 1'b0;
      #1;
      chk("s2_instr", instr, 32'h1234_5678);
      chk("s2_next_wrap", nextAddy, 16'h0000);
      tick();
      chk("s2_valid_off", instrValid, 0);
      instrReady = 1'b0;

      // redirect during fetch without ack -> drop late data
      pcAddy = 16'h0100; hlt = 1'b0;
      tick();
      hlt = 1'b1;
      chk("s3_req", imemReq, 1);
      branchTaken = 1'b1; branchTarget = 16'h0200;
      #1;
      chk("s3_next_branch", nextAddy, 16'h0200);
      tick();
      branchTaken = 1'b0;
      #1;
      chk("s3_drop_req", imemReq, 1);
      chk("s3_drop_next", nextAddy, 16'h0100);
      tick();
      tick();
      imemAck = 1'b1; imemData = 32'hBADB_AD00;
      tick();
      imemAck = 1'b0;
      chk("s3_drop_req_off", imemReq, 0);
      chk("s3_drop_novalid", instrValid, 0);
      pcAddy = 16'h0200; hlt = 1'b0;
      tick();
      chk("s3_refetch_addr", imemAddr, 16'h0200);
      chk("s3_refetch_req", imemReq, 1);
      imemAck = 1'b1; imemData = 32'hCAFE_F00D;
      tick();
      imemAck = 1'b0; hlt = 1'b1;
      chk("s3_refetch_instr", instr, 32'hCAFE_F00D);

      // decode stalls five cycles, halt raised while holding
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("s4_hold_valid", instrValid, 1);
         chk("s4_hold_instr", instr, 32'hCAFE_F00D);
         chk("s4_hold_next", nextAddy, 16'h0200);
      end
      instrReady = 1'b1;
      tick();
      instrReady = 1'b0;
      chk("s4_accept", instrValid, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("s4_halt_noreq", imemReq, 0);
      end

      // redirect in HOLD overrides instrReady
      pcAddy = 16'h0300; hlt = 1'b0;
      tick();
      hlt = 1'b1; imemAck = 1'b1; imemData = 32'h1111_2222;
      tick();
      imemAck = 1'b0;
      chk("s5_valid", instrValid, 1);
      branchTaken = 1'b1; branchTarget = 16'h0400; instrReady = 1'b1;
      #1;
      chk("s5_next_branch", nextAddy, 16'h0400);
      tick();
      branchTaken = 1'b0; instrReady = 1'b0;
      chk("s5_discard_valid", instrValid, 0);
      chk("s5_discard_instr", instr, 32'h0000_0013);

      // redirect coincident with ack, then redirect while idle
      pcAddy = 16'h0400; hlt = 1'b0;
      tick();
      hlt = 1'b1; imemAck = 1'b1; imemData = 32'h5555_AAAA; branchTaken = 1'b1;
      tick();
      imemAck = 1'b0; branchTaken = 1'b0;
      chk("s6_ack_branch_valid", instrValid, 0);
      chk("s6_ack_branch_req", imemReq, 0);
      hlt = 1'b0; branchTaken = 1'b1;
      tick();
      branchTaken = 1'b0;
      chk("s6_idle_branch_noreq", imemReq, 0);
      tick();
      chk("s6_idle_resume", imemReq, 1);
      hlt = 1'b1; imemAck = 1'b1; imemData = 32'h0F0F_0F0F; instrReady = 1'b1;
      tick();
      imemAck = 1'b0;
      tick();
      instrReady = 1'b0;

      // reset pulse mid-fetch, late ack ignored
      pcAddy = 16'h0500; hlt = 1'b0;
      tick();
      hlt = 1'b1;
      chk("s7_req", imemReq, 1);
      #1 reset = 1'b0;
      #1;
      chk("s7_rst_req", imemReq, 0);
      chk("s7_rst_addr", imemAddr, 0);
      chk("s7_rst_valid", instrValid, 0);
      chk("s7_rst_instr", instr, 0);
      chk("s7_rst_next", nextAddy, 0);
      imemAck = 1'b1; imemData = 32'h7777_7777;
      tick();
      tick();
      reset = 1'b1;
      tick();
      chk("s7_late_ack_valid", instrValid, 0);
      chk("s7_late_ack_req", imemReq, 0);
      imemAck = 1'b0; hlt = 1'b0;
      tick();
      chk("s7_first_fetch", imemReq, 1);
      chk("s7_first_addr", imemAddr, 16'h0500);
      hlt = 1'b1; imemAck = 1'b1; imemData = 32'h8888_9999;
      tick();
      imemAck = 1'b0; instrReady = 1'b1;
      tick();
      instrReady = 1'b0;

`ifdef FETCH_TIMEOUT_EN
      // watchdog: ack never arrives
      pcAddy = 16'h0600; hlt = 1'b0;
      tick();
      hlt = 1'b1;
      for (int i = 0; i < TO - 1; i++) begin
         tick();
         chk("s8_wait_req", imemReq, 1);
         chk("s8_wait_err", fetchErr, 0);
      end
      tick();
      chk("s8_err", fetchErr, 1);
      chk("s8_req_off", imemReq, 0);
      hlt = 1'b0;
      tick();
      hlt = 1'b1; imemAck = 1'b1; imemData = 32'hABCD_0123;
      tick();
      imemAck = 1'b0;
      chk("s8_err_sticky", fetchErr, 1);
      chk("s8_after_err_instr", instr, 32'hABCD_0123);
      instrReady = 1'b1;
      tick();
      instrReady = 1'b0;
`endif

      tick();
      tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
